// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES BRAM arbiter
package aes_pkg;

  // Native BRAM word width; also the default arbiter data width.
  localparam int AES_WORD_W = 32;

  // Byte distance between consecutive BRAM words as seen by the sequencers.
  localparam int AES_BYTE_STRIDE = 4;

  // Arbiter transfer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } aes_state_e;

endpackage

// File: rtl/aes_bram_arbiter_if.sv
// rtl/aes_bram_arbiter_if.sv - requester and BRAM signal bundle for the arbiter
interface aes_bram_arbiter_if import aes_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = AES_WORD_W
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Requester side
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        req_err;
  logic [DATA_W-1:0]         req_rdata;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;

  // BRAM side
  logic                      bram_start_read;
  logic                      bram_start_write;
  logic [ADDR_W-1:0]         bram_addr;
  logic [DATA_W-1:0]         bram_write_data;
  logic [DATA_W-1:0]         bram_read_data;
  logic                      bram_complete;

  // Arbiter view
  modport slave (
    input  req, req_we, req_addr, req_wdata, bram_complete, bram_read_data,
    output req_done, req_err, req_rdata, grant_id, busy,
           bram_start_read, bram_start_write, bram_addr, bram_write_data
  );

  // Requester/BRAM environment view
  modport master (
    output req, req_we, req_addr, req_wdata, bram_complete, bram_read_data,
    input  req_done, req_err, req_rdata, grant_id, busy,
           bram_start_read, bram_start_write, bram_addr, bram_write_data
  );

endinterface

// File: rtl/aes_rr_pick.sv
// rtl/aes_rr_pick.sv - combinational round-robin priority picker
module aes_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  localparam logic [IDX_W:0] NUM = (IDX_W + 1)'(N);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IDX_W:0] w_off;
  logic [IDX_W:0] w_sum;

  // Rotate the request vector so bit 0 is the requester at the pointer.
  assign w_dbl = {i_req, i_req};
  assign w_rot = N'(w_dbl >> i_ptr);

  // Lowest set bit of the rotated vector is the distance from the pointer.
  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = (IDX_W + 1)'(k);
    end
  end

  assign w_sum   = {1'b0, i_ptr} + w_off;
  assign o_idx   = (w_sum >= NUM) ? IDX_W'(w_sum - NUM) : IDX_W'(w_sum);
  assign o_valid = |i_req;

endmodule

// File: rtl/aes_bram_arbiter.sv
// rtl/aes_bram_arbiter.sv - round-robin BRAM port arbiter; AES_BRAM_ARB_TIMEOUT_EN adds a WAIT watchdog
module aes_bram_arbiter import aes_pkg::*; #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = AES_WORD_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               aes_clk,
  input logic               aes_rst_n,
  aes_bram_arbiter_if.slave bus
);

  localparam int              ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  aes_state_e          r_state, w_state_nxt;
  logic [ID_W-1:0]     r_gid, w_gid_nxt;
  logic [ID_W-1:0]     r_ptr, w_ptr_nxt;
  logic                r_we, w_we_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic                r_start_rd, w_start_rd_nxt;
  logic                r_start_wr, w_start_wr_nxt;
  logic [NUM_REQ-1:0]  r_done, w_done_nxt;

  logic [ID_W-1:0]     w_pick_idx;
  logic                w_pick_valid;
  logic [ID_W-1:0]     w_gid_inc;
  logic [ADDR_W-1:0]   w_addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   w_wdata_arr [NUM_REQ];

  // Configuration constants kept visible in every build.
  logic                w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0) && (AES_BYTE_STRIDE != 0);

`ifdef AES_BRAM_ARB_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0]  r_err, w_err_nxt;
`endif

  // Split the packed per-requester address/data buses into indexable words.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr_arr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign w_wdata_arr[g] = bus.req_wdata[g*DATA_W +: DATA_W];
  end

  aes_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // Pointer moves to the requester after the one just served.
  assign w_gid_inc = (r_gid == LAST_ID) ? '0 : r_gid + 1'b1;

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_gid_nxt      = r_gid;
    w_ptr_nxt      = r_ptr;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_rdata_nxt    = r_rdata;
    w_start_rd_nxt = r_start_rd;
    w_start_wr_nxt = r_start_wr;
    w_done_nxt     = '0;
`ifdef AES_BRAM_ARB_TIMEOUT_EN
    w_cnt_nxt      = r_cnt;
    w_err_nxt      = '0;
`endif

    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt    = WAIT;
          w_gid_nxt      = w_pick_idx;
          w_we_nxt       = bus.req_we[w_pick_idx];
          w_addr_nxt     = w_addr_arr[w_pick_idx];
          w_wdata_nxt    = w_wdata_arr[w_pick_idx];
          w_start_wr_nxt = bus.req_we[w_pick_idx];
          w_start_rd_nxt = !bus.req_we[w_pick_idx];
`ifdef AES_BRAM_ARB_TIMEOUT_EN
          w_cnt_nxt      = '0;
`endif
        end
      end

      WAIT: begin
        if (bus.bram_complete) begin
          w_start_rd_nxt    = 1'b0;
          w_start_wr_nxt    = 1'b0;
          w_done_nxt[r_gid] = 1'b1;
          w_ptr_nxt         = w_gid_inc;
          w_state_nxt       = DONE;
          if (!r_we) w_rdata_nxt = bus.bram_read_data;
        end
`ifdef AES_BRAM_ARB_TIMEOUT_EN
        else if (r_cnt == CNT_LAST) begin
          w_start_rd_nxt   = 1'b0;
          w_start_wr_nxt   = 1'b0;
          w_err_nxt[r_gid] = 1'b1;
          w_ptr_nxt        = w_gid_inc;
          w_state_nxt      = DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt    = IDLE;
        w_start_rd_nxt = 1'b0;
        w_start_wr_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge aes_clk or negedge aes_rst_n) begin
    if (!aes_rst_n) begin
      r_state    <= IDLE;
      r_gid      <= '0;
      r_ptr      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_start_rd <= 1'b0;
      r_start_wr <= 1'b0;
      r_done     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gid      <= w_gid_nxt;
      r_ptr      <= w_ptr_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_rdata    <= w_rdata_nxt;
      r_start_rd <= w_start_rd_nxt;
      r_start_wr <= w_start_wr_nxt;
      r_done     <= w_done_nxt;
    end
  end

`ifdef AES_BRAM_ARB_TIMEOUT_EN
  // Watchdog counter and timeout pulse registers.
  always_ff @(posedge aes_clk or negedge aes_rst_n) begin
    if (!aes_rst_n) begin
      r_cnt <= '0;
      r_err <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign bus.req_err = r_err;
`else
  assign bus.req_err = '0;
`endif

  assign bus.req_done         = r_done;
  assign bus.req_rdata        = r_rdata;
  assign bus.grant_id         = r_gid;
  assign bus.busy             = (r_state != IDLE);
  assign bus.bram_start_read  = r_start_rd;
  assign bus.bram_start_write = r_start_wr;
  assign bus.bram_addr        = r_addr;
  assign bus.bram_write_data  = r_wdata;

endmodule

// File: doc/aes_bram_arbiter.md
Name: aes_bram_arbiter

Overview:
- Shares the single word-wide BRAM port between NUM_REQ independent requesters, e.g. per-core read/write sequencers when AES cores are split into separate channels.
- Arbitrates round-robin, drives the BRAM start_read/start_write/complete handshake, returns read data and a one-cycle done pulse to the winner.
- Sits between the AES sequencers and the BRAM/AXI bridge.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, byte address width.
- DATA_W, 32, BRAM word width.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- aes_clk  in  1  clock; all logic on rising edge.
- aes_rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_we  in  NUM_REQ  1 = write, 0 = read; per requester.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing.
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_err  out  NUM_REQ  one-cycle timeout pulse; tied 0 without the optional feature.
- req_rdata  out  DATA_W  read data captured on completion; valid while req_done is high.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last grant.
- busy  out  1  high in any state except IDLE.
- bram_start_read  out  1  read request level to BRAM.
- bram_start_write  out  1  write request level to BRAM.
- bram_addr  out  ADDR_W  BRAM address.
- bram_write_data  out  DATA_W  BRAM write data.
- bram_complete  in  1  BRAM completion level.

Behaviour:
- Reset (async, any state including mid-transfer): all outputs 0; state IDLE; round-robin pointer 0. An in-flight BRAM access is abandoned; no done or err pulse is produced.
- State IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise select the first set bit searching from the pointer upward, wrapping modulo NUM_REQ.
  - On that edge, register grant_id, bram_addr, bram_write_data and the direction. Assert bram_start_write if req_we is set, else bram_start_read. Go to WAIT.
- State WAIT:
  - Hold start and address/data stable while bram_complete is low.
  - On the first edge where bram_complete is high: deassert the start signal, capture req_rdata from the BRAM read data if this was a read, set req_done[grant_id] for one cycle, pointer <= grant_id+1 (wrap to 0 at NUM_REQ). Go to DONE.
- State DONE: clear req_done, return to IDLE. This cycle lets bram_complete fall.
- Latency: a request seen in IDLE at edge N gives start high after edge N. With complete high for k cycles, done is high after edge N+k+1. Minimum turnaround is 3 cycles per word.
- Requester rules: hold req, req_we, req_addr and req_wdata stable until req_done. Drop req on the edge where done is seen, or keep it high to request the next word.
- A req bit still high in IDLE is treated as a new request.
- A request dropped during WAIT does not cancel the access: the BRAM access completes and req_done still pulses.
- Simultaneous requests: strict round-robin. With all NUM_REQ requesting continuously, each is served once every NUM_REQ grants.
- If bram_complete is already high on entry to WAIT, completion occurs on the next edge. No glitch protection is provided.
- bram_start_read and bram_start_write are never high together.

Optional Feature:
- Macro: AES_BRAM_ARB_TIMEOUT_EN.
- When defined: a counter of width $clog2(TIMEOUT_CYCLES)+1 clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES without bram_complete: deassert start, pulse req_err[grant_id] (not req_done), advance the pointer, go to DONE.
- When undefined: no counter is instantiated, WAIT can last indefinitely, and req_err is constant 0.

Decomposition:
- Shared package aes_pkg holds:
  - state enum: IDLE=0, WAIT=1, DONE=2;
  - the BRAM word width constant;
  - the byte stride constant 4.
- One natural sub-module: aes_rr_pick, a combinational round-robin priority picker. Inputs: request vector and pointer. Outputs: grant index and valid. Reusable for a future multi-core dispatch scheduler.

Test Plan:
- Single read: req=01, addr0=0x100, BRAM returns 0xDEADBEEF with complete after 3 cycles -> bram_start_read high for 3 cycles, bram_addr=0x100, req_done=01 for one cycle, req_rdata=0xDEADBEEF.
- Write path: req=10, we=1, addr1=0x200, wdata=0x12345678 -> bram_start_write only, bram_write_data=0x12345678, req_done=10, bram_start_read never high.
- Contention: req=11 held for 4 grants from reset -> grant_id sequence 0,1,0,1; each requester gets exactly 2 done pulses.
- Pointer wrap with NUM_REQ=4: req=1001 after a grant to 3 -> next grant 0, then 3.
- Reset mid-WAIT: deassert aes_rst_n while bram_start_read is high -> all outputs 0 immediately; no req_done; the next request is granted from pointer 0.
- Timeout (AES_BRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): bram_complete held low -> req_err pulses after 16 WAIT cycles, start deasserts, req_done stays 0, busy returns to 0 two cycles later.
